// File: rtl/fmap_loader_pkg.sv
// Shared feature-map geometry for the loader and the pooling stages that consume its frames.
package fmap_loader_pkg;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_DIM   = 8;
    localparam int FRAME_PIX = DEF_DIM * DEF_DIM;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_width(FRAME_PIX);

endpackage

// File: rtl/fmap_loader_bank.sv
// One frame bank: DEPTH x PIX_W registers, single write port, whole bank visible as a flat vector.
module fmap_bank #(
    parameter int PIX_W = 8,
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_we,
    input  logic [IDX_W-1:0]       i_idx,
    input  logic [PIX_W-1:0]       i_data,
    output logic [DEPTH*PIX_W-1:0] o_flat
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_idx] <= i_data;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign o_flat[g*PIX_W +: PIX_W] = r_mem[g];
    end

endmodule

// File: rtl/fmap_loader.sv
// Ping-pong frame loader: collects a row-major pixel stream into two banks and presents
// completed frames in order to the pooling stage, with framing-error detection on pix_last.
module fmap_loader
    import fmap_loader_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int DIM   = DEF_DIM
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [PIX_W-1:0]         pix_data,
    input  logic                     pix_last,
    output logic [DIM*DIM*PIX_W-1:0] feature_map,
    output logic                     frame_valid,
    input  logic                     frame_ack,
    output logic                     frame_err,
    output logic [7:0]               frame_cnt
);

    localparam int NPIX = DIM * DIM;
    localparam int IW   = idx_width(NPIX);
    localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);

    logic [IW-1:0]         r_pix_cnt;
    logic                  r_wr_sel;
    logic                  r_rd_sel;
    logic [1:0]            r_full;
    logic [7:0]            r_frame_cnt;
    logic                  r_frame_err;

    logic                  w_accept;
    logic                  w_final;
    logic                  w_early;
    logic                  w_missing;
    logic                  w_ack;
    logic [1:0]            w_full_nxt;
    logic [NPIX*PIX_W-1:0] w_bank0;
    logic [NPIX*PIX_W-1:0] w_bank1;

    // Handshake: a pixel transfers on a rising edge where pix_valid && pix_ready;
    // a frame is released on a rising edge where frame_ack && frame_valid.
    assign pix_ready   = !r_full[r_wr_sel];
    assign w_accept    = pix_valid && pix_ready;
    assign w_final     = w_accept && (r_pix_cnt == LAST_IDX);
    assign w_early     = w_accept && pix_last && (r_pix_cnt != LAST_IDX);
    assign w_missing   = w_final && !pix_last;
    assign w_ack       = frame_ack && r_full[r_rd_sel];

    // Completion and release never target the same bank: completing needs the write bank
    // free, and when wr_sel == rd_sel that same bank is the one an ack would release.
    always_comb begin
        w_full_nxt = r_full;
        if (w_final) w_full_nxt[r_wr_sel] = 1'b1;
        if (w_ack)   w_full_nxt[r_rd_sel] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt   <= '0;
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_full      <= 2'b00;
            r_frame_cnt <= 8'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_full      <= w_full_nxt;
            r_frame_err <= w_early || w_missing;
            if (w_ack) r_rd_sel <= !r_rd_sel;
            if (w_final) begin
                r_pix_cnt   <= '0;
                r_wr_sel    <= !r_wr_sel;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end else if (w_early) begin
                r_pix_cnt   <= '0;
            end else if (w_accept) begin
                r_pix_cnt   <= r_pix_cnt + 1'b1;
            end
        end
    end

    fmap_bank #(.PIX_W(PIX_W), .DEPTH(NPIX), .IDX_W(IW)) u_bank0 (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_accept && !r_wr_sel),
        .i_idx  (r_pix_cnt),
        .i_data (pix_data),
        .o_flat (w_bank0)
    );

    fmap_bank #(.PIX_W(PIX_W), .DEPTH(NPIX), .IDX_W(IW)) u_bank1 (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_accept && r_wr_sel),
        .i_idx  (r_pix_cnt),
        .i_data (pix_data),
        .o_flat (w_bank1)
    );

    assign feature_map = r_rd_sel ? w_bank1 : w_bank0;
    assign frame_valid = r_full[r_rd_sel];
    assign frame_err   = r_frame_err;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_fmap_loader.sv
// Directed bench for fmap_loader: frame assembly, ping-pong back-pressure, framing errors, reset.
module tb_fmap_loader;

    localparam int PIX_W = 8;
    localparam int DIM   = 8;
    localparam int NPIX  = DIM * DIM;
    localparam int FM_W  = NPIX * PIX_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pix_valid = 1'b0;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data = '0;
    logic              pix_last = 1'b0;
    logic [FM_W-1:0]   feature_map;
    logic              frame_valid;
    logic              frame_ack = 1'b0;
    logic              frame_err;
    logic [7:0]        frame_cnt;

    int checks = 0;
    int errors = 0;
    logic [FM_W-1:0] exp_q[$];

    fmap_loader #(.PIX_W(PIX_W), .DIM(DIM)) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_last    (pix_last),
        .feature_map (feature_map),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt)
    );

    // clock / reset
    always #5 clk = !clk;

    task automatic check(input string tag, input logic [FM_W-1:0] obs, input logic [FM_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FM_W-1:0] make_frame(input int base);
        logic [FM_W-1:0] f;
        f = '0;
        for (int i = 0; i < NPIX; i++) f[i*PIX_W +: PIX_W] = PIX_W'(base + i);
        return f;
    endfunction

    function automatic logic [FM_W-1:0] exp_head();
        return (exp_q.size() > 0) ? exp_q[0] : '0;
    endfunction

    // driver tasks: inputs change just after a falling edge, outputs sampled at falling edges
    task automatic send_pix(input logic [PIX_W-1:0] d, input logic l);
        int t;
        t = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = l;
        while (!pix_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("ready_timeout", {{(FM_W-1){1'b0}}, pix_ready}, 1);
        @(negedge clk);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic send_frame(input int base, input int n, input int last_at);
        for (int i = 0; i < n; i++) send_pix(PIX_W'(base + i), i == last_at);
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        void'(exp_q.pop_front());
    endtask

    initial begin
        // reset state
        @(negedge clk);
        check("rst_ready", pix_ready, 1);
        check("rst_fvalid", frame_valid, 0);
        check("rst_fmap", feature_map, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_err", frame_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // single frame, value = index
        send_frame(0, NPIX, NPIX - 1);
        exp_q.push_back(make_frame(0));
        check("f1_valid", frame_valid, 1);
        check("f1_fmap", feature_map, exp_head());
        check("f1_r3c5", feature_map[(3*DIM+5)*PIX_W +: PIX_W], 29);
        check("f1_r7c7", feature_map[(7*DIM+7)*PIX_W +: PIX_W], 63);
        check("f1_cnt", frame_cnt, 1);
        check("f1_err", frame_err, 0);
        ack_frame();
        check("f1_ack_valid", frame_valid, 0);
        check("ack_idle_ignored_cnt", frame_cnt, 1);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("idle_ack_valid", frame_valid, 0);
        check("idle_ack_ready", pix_ready, 1);

        // two frames without ack, third stalls
        send_frame(100, NPIX, NPIX - 1);
        exp_q.push_back(make_frame(100));
        send_frame(200, NPIX, NPIX - 1);
        exp_q.push_back(make_frame(200));
        check("full_ready", pix_ready, 0);
        check("full_valid", frame_valid, 1);
        check("full_fmap", feature_map, exp_head());
        check("full_cnt", frame_cnt, 3);
        pix_valid = 1'b1;
        pix_data  = PIX_W'(50);
        pix_last  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_ready", pix_ready, 0);
            check("stall_fmap_hold", feature_map, exp_head());
        end
        frame_ack = 1'b1;
        check("ack_cycle_ready", pix_ready, 0);
        @(negedge clk);
        frame_ack = 1'b0;
        void'(exp_q.pop_front());
        check("post_ack_ready", pix_ready, 1);
        check("post_ack_valid", frame_valid, 1);
        check("post_ack_fmap", feature_map, exp_head());

        // third frame resumes; its final pixel coincides with the ack of frame 2
        send_frame(50, NPIX - 1, -1);
        check("f3_pre_cnt", frame_cnt, 3);
        pix_valid = 1'b1;
        pix_data  = PIX_W'(50 + NPIX - 1);
        pix_last  = 1'b1;
        frame_ack = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        frame_ack = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(make_frame(50));
        check("swap_valid", frame_valid, 1);
        check("swap_fmap", feature_map, exp_head());
        check("swap_cnt", frame_cnt, 4);
        check("swap_err", frame_err, 0);
        check("swap_ready", pix_ready, 1);
        ack_frame();
        check("swap_drain_valid", frame_valid, 0);

        // early pix_last on 10th pixel
        send_frame(7, 10, 9);
        check("early_err", frame_err, 1);
        check("early_cnt", frame_cnt, 4);
        check("early_valid", frame_valid, 0);
        @(negedge clk);
        check("early_err_pulse", frame_err, 0);
        send_frame(33, NPIX, NPIX - 1);
        exp_q.push_back(make_frame(33));
        check("recover_valid", frame_valid, 1);
        check("recover_fmap", feature_map, exp_head());
        check("recover_cnt", frame_cnt, 5);
        check("recover_err", frame_err, 0);
        ack_frame();

        // missing pix_last on final pixel
        send_frame(90, NPIX, -1);
        exp_q.push_back(make_frame(90));
        check("miss_valid", frame_valid, 1);
        check("miss_err", frame_err, 1);
        check("miss_fmap", feature_map, exp_head());
        check("miss_cnt", frame_cnt, 6);
        @(negedge clk);
        check("miss_err_pulse", frame_err, 0);

        // reset mid-frame with one frame buffered
        send_frame(11, 30, -1);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_valid", frame_valid, 0);
        check("arst_ready", pix_ready, 1);
        check("arst_fmap", feature_map, 0);
        check("arst_cnt", frame_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", frame_valid, 0);
        check("post_rst_fmap", feature_map, 0);
        send_frame(170, NPIX, NPIX - 1);
        exp_q.push_back(make_frame(170));
        check("post_rst_f_valid", frame_valid, 1);
        check("post_rst_f_fmap", feature_map, exp_head());
        check("post_rst_f_cnt", frame_cnt, 1);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/fmap_loader.md
FMAP_LOADER -- requirements
Module: fmap_loader

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter DIM, default 8, feature-map side length (frame = DIM*DIM pixels, row-major).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pix_valid  input  1  upstream pixel valid.
REQ-006 SHALL have port pix_ready  output  1  loader can accept a pixel this cycle.
REQ-007 SHALL have port pix_data  input  PIX_W  pixel value.
REQ-008 SHALL have port pix_last  input  1  marks final pixel of a frame.
REQ-009 SHALL have port feature_map  output  DIM*DIM*PIX_W  completed frame; element [r][c] at bits ((r*DIM+c)*PIX_W) upward.
REQ-010 SHALL have port frame_valid  output  1  feature_map holds a complete frame.
REQ-011 SHALL have port frame_ack  input  1  downstream pooling stage has consumed the presented frame.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a framing error.
REQ-013 SHALL have port frame_cnt  output  8  count of completed frames, wraps 255->0.

Function
REQ-014 SHALL hold two frame banks (ping-pong), a write select wr_sel, a read select rd_sel and a full flag per bank.
REQ-015 SHALL accept a pixel only on pix_valid && pix_ready; pix_ready = !full[wr_sel], combinational from registered state.
REQ-016 SHALL write each accepted pixel to bank wr_sel at index pix_cnt (0..DIM*DIM-1, row-major), then increment pix_cnt.
REQ-017 SHALL, on acceptance at pix_cnt = DIM*DIM-1: set full[wr_sel], toggle wr_sel, clear pix_cnt, increment frame_cnt.
REQ-018 SHALL drive frame_valid = full[rd_sel] and feature_map = contents of bank rd_sel.
REQ-019 SHALL make frame_valid rise the cycle after the final pixel is accepted when that bank is rd_sel (latency 1).
REQ-020 SHALL, on frame_ack && frame_valid: clear full[rd_sel], toggle rd_sel; frame_ack with frame_valid low is ignored.
REQ-021 SHALL apply completion and frame_ack in the same cycle independently (they always target different banks when both full flags matter); no pixel lost, no frame duplicated.
REQ-022 SHALL, with both banks full, hold pix_ready low until frame_ack frees a bank; pix_ready rises the cycle after the ack.
REQ-023 SHALL, on accepted pix_last with pix_cnt < DIM*DIM-1 (early last): discard the partial frame, clear pix_cnt, not set full, not increment frame_cnt, pulse frame_err.
REQ-024 SHALL, on the final pixel accepted without pix_last (missing last): complete the frame normally and pulse frame_err.
REQ-025 SHALL keep bank contents unchanged while full (no write to a full bank is possible).

Reset
REQ-026 SHALL, while rst is high: pix_cnt=0, wr_sel=0, rd_sel=0, full=00, frame_cnt=0, frame_err=0, all bank storage=0.
REQ-027 SHALL therefore present pix_ready=1, frame_valid=0, feature_map=0 during and immediately after reset.
REQ-028 SHALL, on reset mid-frame or with frames pending, discard all partial and buffered frames.

Structure
REQ-029 SHALL take PIX_W, DIM defaults and derived FRAME_PIX=DIM*DIM and index width from a shared package also used by minimum pooling stages.
REQ-030 SHALL instantiate sub-module fmap_bank twice: one DIM*DIM x PIX_W register bank with write-enable/index/data port, flat read-out, async reset to 0.

Verification
REQ-031 SHALL cover: reset then 64 pixels value=index with pix_last on 64th -> frame_valid one cycle later, feature_map[r][c]=r*8+c, frame_cnt=1, frame_err=0.
REQ-032 SHALL cover: three frames back-to-back, no ack -> after 128 pixels pix_ready=0; frame 3 stalled; ack -> pix_ready=1 next cycle, frame 2 presented.
REQ-033 SHALL cover: frame_ack in same cycle as final pixel of next frame -> frame_valid stays high, feature_map switches to new frame, no pixel dropped.
REQ-034 SHALL cover: pix_last on 10th pixel -> frame_err pulse, frame_cnt unchanged, next 64 pixels form a correct frame.
REQ-035 SHALL cover: 64th pixel without pix_last -> frame_valid=1 and frame_err pulse same cycle.
REQ-036 SHALL cover: rst asserted after 30 pixels with one frame buffered -> frame_valid=0, pix_ready=1, feature_map=0, frame_cnt=0 immediately.
